csa_resolve_pipe: RTL
=====================

// Module: csa_resolve_pipe
// PURPOSE
//  Consumer side of the carry-save datapath: takes a redundant (sum, carry) pair as produced
//  by 3:2 compressor trees and resolves it to a plain binary value, sum + (carry << 1).
//  The carry-propagate add is split into NUM_STAGES pipelined chunks with valid/ready flow
//  control on both sides. Sits between the RVV multiply/MAC compressor tree and writeback.
// PARAMETERS
//  WIDTH       32  width of in_sum / in_carry; carry bit i carries weight 2^(i+1)
//  NUM_STAGES  2   pipeline depth; each stage resolves WIDTH/NUM_STAGES bits; WIDTH%NUM_STAGES==0
//  TAG_WIDTH   4   sideband tag carried alongside each item, unmodified
// PORTS
//  clk         in   1            clock, rising edge
//  rst_n       in   1            asynchronous reset, active low
//  in_valid    in   1            input item valid
//  in_ready    out  1            block can accept input this cycle
//  in_sum      in   WIDTH        carry-save sum vector
//  in_carry    in   WIDTH        carry-save carry vector (unshifted; weight 2^(i+1))
//  in_tag      in   TAG_WIDTH    sideband tag
//  out_valid   out  1            resolved result valid
//  out_ready   in   1            downstream accepts result
//  out_result  out  WIDTH+2      exact in_sum + (in_carry<<1), no truncation
//  out_tag     out  TAG_WIDTH    tag of the item on out_result
// BEHAVIOUR
//  - Arithmetic: A={2'b0,in_sum}, B={1'b0,in_carry,1'b0}; out_result = A+B (WIDTH+2 bits, exact).
//  - Chunk C=WIDTH/NUM_STAGES. Stage k (0..NUM_STAGES-1) adds bits [k*C +: C] of A and B plus
//    carry-in from stage k-1 (0 for stage 0); registers resolved low bits, its carry-out, and
//    the still-unresolved upper bits of A and B. Last stage also adds bits [WIDTH+1:WIDTH].
//  - Each stage holds a valid bit v[k]. Stage k loads when !v[k] || advance[k+1];
//    advance[NUM_STAGES] = out_ready. in_ready = !v[0] || advance[1] (combinational, no skid).
//  - Transfer occurs on in_valid&&in_ready / out_valid&&out_ready at posedge clk.
//  - Latency: accepted at edge N -> out_valid high after edge N+NUM_STAGES-1... i.e. visible
//    NUM_STAGES cycles after acceptance. Throughput 1 item/cycle when out_ready stays high.
//  - out_valid = v[NUM_STAGES-1]; out_result/out_tag stable while out_valid && !out_ready.
//  - Capacity NUM_STAGES items; in order; no item dropped or duplicated under any backpressure.
//  - Simultaneous accept at input and output with pipeline full: both occur same cycle.
//  - A stage with v=0 does not update data regs (power); data content when invalid is don't-care.
//  - in_sum/in_carry/in_tag are sampled only when in_valid && in_ready.
//  - Reset (async assert, any time incl. mid-stream): all v[k]=0, out_valid=0, in_ready=1
//    after reset, out_result=0, out_tag=0, all stage data regs 0. In-flight items discarded.
//  - Deassertion of rst_n is assumed synchronised externally; first accept possible next edge.
//  - in_valid must not drop before acceptance; data must stay stable while in_valid && !in_ready
//    (checked by bench assertion, not by RTL).
// TESTING  (WIDTH=8, NUM_STAGES=2, TAG_WIDTH=4 unless noted)
//  1 Basic: sum=0x05,carry=0x03,tag=1, out_ready=1 -> out_result=0x00B, tag=1, 2 cycles later.
//  2 Max/cross-chunk: sum=0xFF,carry=0xFF -> 0x2FD; sum=0x0F,carry=0x01 -> 0x011 (chunk carry).
//  3 Streaming: 16 random items back-to-back, out_ready=1 -> 16 results consecutive cycles,
//    in order, match golden sum+(carry<<1), in_ready never low.
//  4 Backpressure: out_ready=0, push 3 items -> 2 accepted, in_ready=0 on 3rd; out_result
//    stable; release out_ready -> items emerge in order, 3rd accepted same cycle as 1st drains.
//  5 Reset mid-op: 2 items in flight, pulse rst_n low async between edges -> out_valid=0,
//    in_ready=1, out_result=0 immediately; no stale item appears after release.
//  6 Param sweep: WIDTH=32,NUM_STAGES=4 random+corner (0, all-ones, alternating 0x55/0xAA)
//    with random out_ready -> scoreboard clean, latency 4.

Source files
------------

// File: rtl/csa_resolve_pipe_if.sv
// Handshake bundle for the carry-save resolver: redundant (sum, carry) input stream
// and resolved binary output stream, each with valid/ready flow control.
interface csa_resolve_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic [WIDTH-1:0]     in_carry;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH+1:0]     out_result;
    logic [TAG_WIDTH-1:0] out_tag;

    // The resolver is the slave of the input stream and master of the output stream.
    modport slave (
        input  in_valid, in_sum, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

    modport master (
        output in_valid, in_sum, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-propagate adder resolving a carry-save pair into sum + (carry << 1),
// one WIDTH/NUM_STAGES-bit chunk per stage, with valid/ready flow control on both sides.
module csa_resolve_pipe #(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    csa_resolve_pipe_if.slave s
);
    localparam int C  = WIDTH / NUM_STAGES;
    localparam int RW = WIDTH + 2;

    logic [NUM_STAGES-1:0]                v_q, v_d;
    logic [NUM_STAGES-1:0]                cy_q, cy_d, cy_in;
    logic [NUM_STAGES-1:0]                stage_load, stage_fill, stage_en;
    logic [NUM_STAGES-1:0][RW-1:0]        a_q, a_d, a_in;
    logic [NUM_STAGES-1:0][RW-1:0]        b_q, b_d, b_in;
    logic [NUM_STAGES-1:0][TAG_WIDTH-1:0] tag_q, tag_d, tag_in;
    logic                                 unused_bits;

    // A stage may load when empty or when its current item moves on; this ripples
    // back from the output so a full pipeline still accepts when the tail drains.
    always_comb begin
        stage_load = '0;
        stage_load[NUM_STAGES-1] = !v_q[NUM_STAGES-1] || s.out_ready;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            stage_load[k] = !v_q[k] || stage_load[k+1];
        end
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic [C:0]    chunk;
        logic [RW-1:0] resolved;

        if (gi == 0) begin : g_first
            assign a_in[gi]       = {2'b00, s.in_sum};
            assign b_in[gi]       = {1'b0, s.in_carry, 1'b0};
            assign cy_in[gi]      = 1'b0;
            assign tag_in[gi]     = s.in_tag;
            assign stage_fill[gi] = s.in_valid;
        end else begin : g_next
            assign a_in[gi]       = a_q[gi-1];
            assign b_in[gi]       = b_q[gi-1];
            assign cy_in[gi]      = cy_q[gi-1];
            assign tag_in[gi]     = tag_q[gi-1];
            assign stage_fill[gi] = v_q[gi-1];
        end

        assign chunk = {1'b0, a_in[gi][gi*C +: C]} + {1'b0, b_in[gi][gi*C +: C]}
                     + {{C{1'b0}}, cy_in[gi]};

        // Resolved bits overwrite A in place; the upper part of A stays unresolved.
        always_comb begin
            resolved = a_in[gi];
            resolved[gi*C +: C] = chunk[C-1:0];
            if (gi == NUM_STAGES - 1) begin
                resolved[RW-1:WIDTH] = a_in[gi][RW-1:WIDTH] + b_in[gi][RW-1:WIDTH]
                                     + {1'b0, chunk[C]};
            end
        end

        assign stage_en[gi] = stage_load[gi] && stage_fill[gi];
        assign v_d[gi]      = stage_load[gi] ? stage_fill[gi] : v_q[gi];
        assign a_d[gi]      = stage_en[gi] ? resolved   : a_q[gi];
        assign b_d[gi]      = stage_en[gi] ? b_in[gi]   : b_q[gi];
        assign cy_d[gi]     = stage_en[gi] ? chunk[C]   : cy_q[gi];
        assign tag_d[gi]    = stage_en[gi] ? tag_in[gi] : tag_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cy_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else begin
            v_q   <= v_d;
            cy_q  <= cy_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
        end
    end

    assign s.in_ready   = stage_load[0];
    assign s.out_valid  = v_q[NUM_STAGES-1];
    assign s.out_result = a_q[NUM_STAGES-1];
    assign s.out_tag    = tag_q[NUM_STAGES-1];

    // Already-consumed low bits of B and the final carry are never read downstream.
    assign unused_bits = ^{b_q, b_in, cy_q};
endmodule
